// File: rtl/button_irq_ctrl_pkg.sv
// Shared RatCPU I/O definitions: port IDs, IRQ FSM states and the default button count.
package rat_io_pkg;

  localparam int NUM_BTN_DEF = 4;

  localparam logic [7:0] PID_SWITCHES = 8'h20;
  localparam logic [7:0] PID_BUTTONS  = 8'h24;
  localparam logic [7:0] PID_LEDS     = 8'h40;
  localparam logic [7:0] PID_SEG      = 8'h81;
  localparam logic [7:0] PID_CLR      = 8'h42;
  localparam logic [7:0] PID_MASK     = 8'h43;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ARMED  = 2'd2
  } irq_state_t;

endpackage

// File: rtl/button_irq_ctrl_if.sv
// CPU-side port bus: OUT strobe/ID/data towards the button block, STATUS/INTERRUPT back.
interface button_irq_ctrl_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] STATUS;
  logic       INTERRUPT;

  modport master (output PORT_ID, OUT_PORT, IO_STRB, input STATUS, INTERRUPT);
  modport slave  (input PORT_ID, OUT_PORT, IO_STRB, output STATUS, INTERRUPT);
endinterface

// File: rtl/button_irq_ctrl_btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and a one-cycle rising-edge pulse
// on the debounced level.
module btn_debounce #(
  parameter int DB_COUNT = 500000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);
  localparam int CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_q;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      // Any return to the accepted level restarts the count, so a bouncy input never wins.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_stable & ~r_stable_q;
endmodule

// File: rtl/button_irq_ctrl.sv
// Push-button front end for RatCPU: debounced edges latch into pending, enabled pending
// buttons raise INTERRUPT; the CPU clears pending (write-1) and sets the mask via OUT.
module button_irq_ctrl
  import rat_io_pkg::*;
#(
  parameter int         NUM_BTN  = NUM_BTN_DEF,
  parameter int         DB_COUNT = 500000,
  parameter int         IRQ_LEN  = 1,
  parameter logic [7:0] CLR_ID   = PID_CLR,
  parameter logic [7:0] MASK_ID  = PID_MASK
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_BTN-1:0] BTN,
  button_irq_ctrl_if.slave   bus
);
  localparam int CW = (IRQ_LEN > 1) ? $clog2(IRQ_LEN) : 1;
  localparam logic [CW-1:0] IRQ_LOAD = CW'(IRQ_LEN - 1);

  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_clr;
  logic [NUM_BTN-1:0] w_pending_next;
  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] r_mask;
  logic               w_clr_wr;
  logic               w_mask_wr;
  logic               w_req;
  logic               w_req_after;
  logic               w_irq;
  logic [7:0]         w_status;
  irq_state_t         r_state;
  irq_state_t         w_state_next;
  logic [CW-1:0]      r_irq_cnt;
  logic [CW-1:0]      w_irq_cnt_next;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(.DB_COUNT(DB_COUNT)) u_db (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_btn    (BTN[gi]),
        .o_stable (w_stable[gi]),
        .o_rise   (w_rise[gi])
      );
    end
  endgenerate

  assign w_clr_wr  = bus.IO_STRB && (bus.PORT_ID == CLR_ID);
  assign w_mask_wr = bus.IO_STRB && (bus.PORT_ID == MASK_ID);
  assign w_clr     = w_clr_wr ? bus.OUT_PORT[NUM_BTN-1:0] : '0;
  // A rise in the same cycle as its clear survives: the OR comes after the clear.
  assign w_pending_next = (r_pending & ~w_clr) | w_rise;
  assign w_req          = |(r_pending & r_mask);
  assign w_req_after    = |(w_pending_next & r_mask);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pending <= '0;
      r_mask    <= '1;
      r_state   <= IDLE;
      r_irq_cnt <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_mask_wr) r_mask <= bus.OUT_PORT[NUM_BTN-1:0];
      r_state   <= w_state_next;
      r_irq_cnt <= w_irq_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_irq_cnt_next = r_irq_cnt;
    w_irq          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_next   = ASSERT;
          w_irq_cnt_next = IRQ_LOAD;
        end
      end
      ASSERT: begin
        w_irq = 1'b1;
        if (r_irq_cnt == '0) w_state_next = ARMED;
        else w_irq_cnt_next = r_irq_cnt - 1'b1;
      end
      ARMED: begin
        // The ISR acknowledges with a CLR write; if work remains, fire again.
        if (!w_req) begin
          w_state_next = IDLE;
        end else if (w_clr_wr && w_req_after) begin
          w_state_next   = ASSERT;
          w_irq_cnt_next = IRQ_LOAD;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_status
      if (gi < NUM_BTN) begin : g_used
        assign w_status[gi]     = r_pending[gi];
        assign w_status[gi + 4] = w_stable[gi];
      end else begin : g_unused
        assign w_status[gi]     = 1'b0;
        assign w_status[gi + 4] = 1'b0;
      end
    end
  endgenerate

  assign bus.STATUS    = w_status;
  assign bus.INTERRUPT = w_irq;
endmodule

// File: tb/tb_button_irq_ctrl.sv
// Randomised + directed bench for button_irq_ctrl: a reference model queues expected
// STATUS/INTERRUPT each clock, a monitor pops and compares on the falling edge.
module tb_button_irq_ctrl;
  import rat_io_pkg::*;

  localparam int DB = 4;
  localparam int IL = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] BTN = 4'b0000;

  button_irq_ctrl_if bus();

  button_irq_ctrl #(
    .NUM_BTN (4),
    .DB_COUNT(DB),
    .IRQ_LEN (IL),
    .CLR_ID  (8'h42),
    .MASK_ID (8'h43)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .BTN  (BTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] status;
    logic       irq;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: button sample history, accepted levels, pending/mask, and the
  // interrupt described as "cycles of high still owed" plus "waiting for acknowledge".
  bit       m_live = 1'b0;
  bit [3:0] m_stable;
  bit [3:0] m_rise;
  bit [3:0] m_pending;
  bit [3:0] m_mask;
  int       m_fire_left;
  bit       m_waiting;
  bit       hist[4][$];

  // A level is accepted once the DB most recent synchronised samples (samples lag the
  // pin by two clocks) all disagree with the currently accepted level.
  function automatic bit level_changes(int b);
    int n;
    n = hist[b].size();
    for (int j = n - 1 - DB; j <= n - 2; j++)
      if (hist[b][j] == m_stable[b]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit [3:0] clr;
    bit [3:0] new_pend;
    bit [3:0] new_stable;
    bit       clr_wr;
    bit       req_now;
    bit       req_after;
    if (RESET) begin
      m_live      = 1'b1;
      m_stable    = '0;
      m_rise      = '0;
      m_pending   = '0;
      m_mask      = 4'hF;
      m_fire_left = 0;
      m_waiting   = 1'b0;
      for (int b = 0; b < 4; b++) begin
        hist[b].delete();
        for (int k = 0; k < DB + 2; k++) hist[b].push_back(1'b0);
      end
    end else if (m_live) begin
      clr_wr    = bus.IO_STRB && (bus.PORT_ID == 8'h42);
      clr       = clr_wr ? bus.OUT_PORT[3:0] : 4'h0;
      new_pend  = (m_pending & ~clr) | m_rise;
      req_now   = |(m_pending & m_mask);
      req_after = |(new_pend & m_mask);
      if (m_fire_left > 0) begin
        m_fire_left--;
        if (m_fire_left == 0) m_waiting = 1'b1;
      end else if (m_waiting) begin
        if (!req_now) m_waiting = 1'b0;
        else if (clr_wr && req_after) begin
          m_waiting   = 1'b0;
          m_fire_left = IL;
        end
      end else if (req_now) begin
        m_fire_left = IL;
      end
      if (bus.IO_STRB && (bus.PORT_ID == 8'h43)) m_mask = bus.OUT_PORT[3:0];
      for (int b = 0; b < 4; b++) begin
        new_stable[b] = level_changes(b) ? ~m_stable[b] : m_stable[b];
        hist[b].push_back(BTN[b]);
        if (hist[b].size() > DB + 3) void'(hist[b].pop_front());
      end
      m_rise    = new_stable & ~m_stable;
      m_stable  = new_stable;
      m_pending = new_pend;
    end
    if (m_live) exp_q.push_back('{status: {m_stable, m_pending}, irq: (m_fire_left > 0)});
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Monitor: outputs are valid every cycle once reset has been seen.
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (m_live) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.STATUS !== e.status) begin
          n_fail++;
          $display("FAIL status: got %02h required %02h at %0t", bus.STATUS, e.status, $time);
        end
        n_checks++;
        if (bus.INTERRUPT !== e.irq) begin
          n_fail++;
          $display("FAIL interrupt: got %b required %b at %0t", bus.INTERRUPT, e.irq, $time);
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(logic [3:0] v, int hold);
    BTN = v;
    $display("btn=%b hold=%0d at %0t", v, hold, $time);
    idle(hold);
  endtask

  task automatic io_write(logic [7:0] id, logic [7:0] data);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    $display("out id=%02h data=%02h at %0t", id, data, $time);
    @(negedge CLK);
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
  endtask

  task automatic do_reset(int n);
    RESET = 1'b1;
    $display("reset cycles=%0d at %0t", n, $time);
    idle(n);
    RESET = 1'b0;
  endtask

  initial begin
    bit seen;
    int r;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    @(negedge CLK);
    do_reset(2);
    idle(2);

    // Single press of button 0, held, then released (left pending, waiting for ack).
    press(4'b0001, 16);
    press(4'b0000, 12);
    // Bouncing button 1 never settles.
    for (int i = 0; i < 10; i++) press((i % 2 == 0) ? 4'b0010 : 4'b0000, 2);
    press(4'b0000, 10);
    // Second event while waiting, then acknowledge one at a time.
    press(4'b0010, 10);
    press(4'b0000, 10);
    io_write(8'h42, 8'h01);
    idle(8);
    io_write(8'h42, 8'h02);
    idle(8);
    // Masked press, then unmask.
    io_write(8'h43, 8'h0E);
    press(4'b0001, 10);
    press(4'b0000, 10);
    io_write(8'h43, 8'h0F);
    idle(8);
    io_write(8'h42, 8'h0F);
    idle(4);
    // Writes to unrelated ports.
    io_write(8'h40, 8'hFF);
    io_write(8'h41, 8'h00);
    idle(4);

    // Rise of button 2 lands in the same cycle as its clear.
    BTN = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      seen = m_rise[2];
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_rise2: got no rise, required one within 20 cycles");
    end
    io_write(8'h42, 8'h04);
    idle(10);
    press(4'b0000, 8);
    io_write(8'h42, 8'h0F);
    idle(6);

    // Reset while INTERRUPT is high.
    BTN = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      seen = (m_fire_left > 0);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_fire: got no interrupt, required one within 20 cycles");
    end
    do_reset(1);
    press(4'b0000, 10);

    // Random traffic.
    for (int it = 0; it < 1200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 50) press(4'($urandom_range(0, 15)), $urandom_range(1, 8));
      else if (r < 70) io_write(8'h42, 8'($urandom_range(0, 255)));
      else if (r < 80) io_write(8'h43, 8'($urandom_range(0, 255)));
      else if (r < 88) io_write(8'($urandom_range(0, 65)), 8'($urandom_range(0, 255)));
      else if (r < 90) do_reset($urandom_range(1, 2));
      else idle($urandom_range(1, 6));
    end
    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
